// File: rtl/parking_slot_ctrl.sv
// parking_slot_ctrl: occupancy-bitmap parking controller for NUM_SLOTS bays.
// An entry takes the lowest-index free bay. An exit releases the bay named on exit_slot.
// Each accepted event opens the gate for DOOR_HOLD cycles. Refused events give a reject pulse.
// Optional feature macro: PARK_STATS_EN adds saturating total_entries/total_exits counters.
module parking_slot_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter int CNT_W     = $clog2(NUM_SLOTS + 1),
    parameter int DOOR_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_sensor,
    input  logic                 exit_sensor,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [CNT_W-1:0]     free_count,
    output logic [SLOT_W-1:0]    alloc_slot,
    output logic                 door_open,
    output logic                 full,
    output logic                 empty,
    output logic                 reject,
    output logic [1:0]           state
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]          total_entries,
    output logic [15:0]          total_exits
`endif
);

    localparam int TMR_W = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DOOR_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        HOLD     = 2'd3
    } state_t;

    // stage p0: sensor history and registered edge events
    logic                 entry_q_p0, exit_q_p0;
    logic                 entry_evt_p0, exit_evt_p0;
    logic [SLOT_W-1:0]    exit_slot_p0;

    // stage p1: FSM state and bay bookkeeping
    state_t               state_q, state_nxt;
    logic [TMR_W-1:0]     timer_q, timer_nxt;
    logic                 pending_q, pending_nxt;
    logic [NUM_SLOTS-1:0] occ_nxt;
    logic [CNT_W-1:0]     fc_nxt;
    logic [SLOT_W-1:0]    alloc_nxt;
    logic                 door_nxt, reject_nxt;
    logic                 acc_in, acc_out;
    logic [SLOT_W-1:0]    free_idx;
    logic                 exit_ok;

    // Register the sensors and turn their rising edges into one-cycle events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q_p0   <= 1'b0;
            exit_q_p0    <= 1'b0;
            entry_evt_p0 <= 1'b0;
            exit_evt_p0  <= 1'b0;
            exit_slot_p0 <= '0;
        end else begin
            entry_q_p0   <= entry_sensor;
            exit_q_p0    <= exit_sensor;
            entry_evt_p0 <= entry_sensor & ~entry_q_p0;
            exit_evt_p0  <= exit_sensor & ~exit_q_p0;
            exit_slot_p0 <= exit_slot;
        end
    end

    // Priority encoder: the lowest-index free bay wins.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) free_idx = SLOT_W'(i);
        end
    end

    // An exit is valid only for an in-range bay that is currently occupied.
    always_comb begin
        exit_ok = 1'b0;
        if ({1'b0, exit_slot_p0} < (SLOT_W + 1)'(NUM_SLOTS))
            exit_ok = occupancy[exit_slot_p0];
    end

    // Next-state logic. Exits take precedence over entries, and one entry can wait as pending.
    always_comb begin
        state_nxt   = state_q;
        timer_nxt   = timer_q;
        pending_nxt = pending_q;
        occ_nxt     = occupancy;
        fc_nxt      = free_count;
        alloc_nxt   = alloc_slot;
        door_nxt    = door_open;
        reject_nxt  = 1'b0;
        acc_in      = 1'b0;
        acc_out     = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_evt_p0) begin
                    pending_nxt = pending_q | entry_evt_p0;
                    if (exit_ok) begin
                        occ_nxt[exit_slot_p0] = 1'b0;
                        fc_nxt    = free_count + CNT_W'(1);
                        door_nxt  = 1'b1;
                        timer_nxt = TMR_LOAD;
                        state_nxt = OPEN_OUT;
                        acc_out   = 1'b1;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end else if (entry_evt_p0 || pending_q) begin
                    pending_nxt = 1'b0;
                    if (full) begin
                        reject_nxt = 1'b1;
                    end else begin
                        occ_nxt[free_idx] = 1'b1;
                        alloc_nxt = free_idx;
                        fc_nxt    = free_count - CNT_W'(1);
                        door_nxt  = 1'b1;
                        timer_nxt = TMR_LOAD;
                        state_nxt = OPEN_IN;
                        acc_in    = 1'b1;
                    end
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (entry_evt_p0) pending_nxt = 1'b1;
                if (exit_evt_p0)  reject_nxt  = 1'b1;
                if (timer_q == '0) begin
                    door_nxt  = 1'b0;
                    state_nxt = HOLD;
                end else begin
                    timer_nxt = timer_q - TMR_W'(1);
                end
            end
            HOLD: begin
                if (entry_evt_p0) pending_nxt = 1'b1;
                if (exit_evt_p0)  reject_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register the FSM and all outputs. The flags are derived from the same next occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pending_q  <= 1'b0;
            occupancy  <= '0;
            free_count <= CNT_W'(NUM_SLOTS);
            alloc_slot <= '0;
            door_open  <= 1'b0;
            full       <= 1'b0;
            empty      <= 1'b1;
            reject     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            timer_q    <= timer_nxt;
            pending_q  <= pending_nxt;
            occupancy  <= occ_nxt;
            free_count <= fc_nxt;
            alloc_slot <= alloc_nxt;
            door_open  <= door_nxt;
            full       <= &occ_nxt;
            empty      <= ~|occ_nxt;
            reject     <= reject_nxt;
        end
    end

    assign state = state_q;

`ifdef PARK_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating counters of accepted entries and exits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_entries <= '0;
            total_exits   <= '0;
        end else begin
            if (acc_in)  total_entries <= sat_inc16(total_entries);
            if (acc_out) total_exits   <= sat_inc16(total_exits);
        end
    end
`else
    logic unused_acc;
    assign unused_acc = acc_in ^ acc_out;
`endif

endmodule

// File: doc/parking_slot_ctrl.md
Name: parking_slot_ctrl

Overview:
- Parametrised successor to the fixed 4-slot parking FSM. Manages NUM_SLOTS bays with an occupancy bitmap instead of one encoded state per combination.
- Entry allocates the lowest-index free bay. Exit releases the bay named on exit_slot.
- Drives a timed gate, full/empty flags, the free-bay count and reject pulses.
- Sits between debounced gate sensors / bay-select switches and the display/gate driver.

Parameters:
- NUM_SLOTS, 4, number of bays, 2..64.
- SLOT_W, $clog2(NUM_SLOTS), width of a bay index.
- CNT_W, $clog2(NUM_SLOTS+1), width of the free-bay count.
- DOOR_HOLD, 8, cycles the gate stays open per accepted event, >=1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- entry_sensor  in  1  level; car waiting at the entry gate
- exit_sensor  in  1  level; car waiting at the exit gate
- exit_slot  in  SLOT_W  bay being vacated; sampled on an exit event
- occupancy  out  NUM_SLOTS  bit i=1 means bay i is occupied
- free_count  out  CNT_W  number of free bays
- alloc_slot  out  SLOT_W  bay assigned by the last accepted entry
- door_open  out  1  gate open
- full  out  1  occupancy all ones
- empty  out  1  occupancy all zeros
- reject  out  1  one-cycle pulse when an event is refused
- state  out  2  FSM state, for debug

Behaviour:
- Reset values: occupancy=0, free_count=NUM_SLOTS, alloc_slot=0, door_open=0, full=0, empty=1, reject=0, state=IDLE, door timer=0.
- All outputs are registered. full, empty and free_count are consistent with occupancy in the same cycle; they are updated together with it.
- Events are the rising edges of entry_sensor and exit_sensor, detected against a registered copy of each. A sensor held high produces one event only.
- FSM states: IDLE=0, OPEN_IN=1, OPEN_OUT=2, HOLD=3.
- IDLE, exit event, exit_slot < NUM_SLOTS and its bay occupied:
  - clear that bit, free_count+1;
  - door_open=1, timer=DOOR_HOLD-1, go to OPEN_OUT.
- IDLE, exit event on a free bay or exit_slot >= NUM_SLOTS: reject=1 for 1 cycle, no state change.
- IDLE, entry event, not full:
  - set the lowest free bit; alloc_slot = that index; free_count-1;
  - door_open=1, timer=DOOR_HOLD-1, go to OPEN_IN.
- IDLE, entry event while full: reject=1, no state change.
- Entry and exit events in the same cycle: exit is served first; the entry is latched as pending. Only one pending entry is held.
- OPEN_IN / OPEN_OUT:
  - timer decrements each cycle; door_open stays 1;
  - at timer==0: door_open=0 and go to HOLD.
  - New events in these states: entry events are latched as pending (one deep); exit events are dropped with reject=1.
- HOLD:
  - one cycle with the gate closed;
  - if an entry is pending, serve it as in IDLE on the next cycle (it may be rejected if the lot is full);
  - otherwise go to IDLE.
- Latency: event edge -> occupancy/door_open update is 2 cycles (1 cycle edge-detect register + 1 cycle update).
- Lowest-free search is a combinational priority encoder over ~occupancy. Arithmetic is unsigned; free_count never wraps, because rejects guard both limits.
- Reset asserted mid-operation clears everything immediately, including the pending entry and the timer.

Optional Feature:
- Macro: PARK_STATS_EN.
- Defined:
  - adds outputs total_entries[15:0] and total_exits[15:0];
  - each increments on an accepted event and saturates at 16'hFFFF;
  - both clear on reset.
- Undefined: these ports and their registers do not exist. Core behaviour is identical either way.

Test Plan:
- NUM_SLOTS=4, DOOR_HOLD=3; reset, then 4 entry pulses spaced 10 cycles apart:
  - alloc_slot 0,1,2,3; occupancy ends 4'b1111; full=1; free_count=0;
  - door_open high exactly 3 cycles per entry.
- Full lot, 5th entry -> reject pulse for 1 cycle; occupancy unchanged; door_open stays 0.
- occupancy=4'b1111; exit with exit_slot=1, then an entry:
  - occupancy goes to 4'b1101, then back to 4'b1111;
  - alloc_slot=1.
- Exit with exit_slot=2 on an empty bay -> reject=1; free_count unchanged.
- Entry and exit rising in the same cycle with occupancy=4'b0001, exit_slot=0:
  - exit served first (occupancy=0000);
  - after the gate closes and HOLD, the pending entry is served: occupancy=0001, alloc_slot=0.
- Reset asserted during OPEN_IN -> all outputs return to reset values asynchronously; the pending entry is discarded.
